// File: rtl/mfp_srec_ahb_byte_writer.sv
// mfp_srec_ahb_byte_writer
//   AHB-Lite master for the SREC loader path. Byte write requests from the
//   parser are queued in a small FIFO and issued as single byte writes with
//   pipelined address/data phases, HREADY wait states and two-cycle ERROR
//   handling.
//
//   Optional build macro: MFP_SREC_WRITER_BIG_ENDIAN_EN
//     defined   -> write lane = 3 - address[1:0] (big-endian memory images)
//     undefined -> write lane = address[1:0]     (little-endian)
//
// Ports:
//   HCLK, HRESET                   clock, synchronous active-high reset
//   in_valid/in_address/in_byte    one byte write request per valid cycle
//   in_ready                       FIFO not full (status only)
//   busy                           bytes buffered or a transfer outstanding
//   overflow, bus_error            sticky status, cleared by reset only
//   HADDR..HWRITE                  AHB-Lite master outputs
//   HREADY, HRESP                  AHB-Lite slave response
module mfp_srec_ahb_byte_writer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ADDR_KEEP_BITS = 29
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        in_valid,
  input  logic [31:0] in_address,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        busy,
  output logic        overflow,
  output logic        bus_error,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE   = 1;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - ADDR_KEEP_BITS);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10
  } htrans_e;

  logic [39:0] fifo_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  logic        ap_v_q, ap_v_d;
  logic [31:0] ap_addr_q, ap_addr_d;
  logic [7:0]  ap_byte_q, ap_byte_d;
  logic        ap_hold_q, ap_hold_d;
  logic        dp_v_q, dp_v_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        ovf_q, ovf_d;
  logic        berr_q, berr_d;

  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        ap_nonseq, ap_done;
  logic [1:0]  lane;
  logic [39:0] head;
  htrans_e     htrans;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    head       = fifo_q[rd_ptr_q[PW-1:0]];

    // ap_hold_q masks the address phase after the first ERROR cycle while
    // keeping the AP contents so the transfer is reissued afterwards.
    ap_nonseq  = ap_v_q && !ap_hold_q;
    ap_done    = ap_nonseq && HREADY && !HRESP;
    push       = in_valid && !fifo_full;
    pop        = !fifo_empty && (!ap_v_q || ap_done);

`ifdef MFP_SREC_WRITER_BIG_ENDIAN_EN
    lane = ~ap_addr_q[1:0];
`else
    lane = ap_addr_q[1:0];
`endif

    wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d     = ovf_q | (in_valid && fifo_full);
    berr_d    = berr_q | (HRESP && !HREADY);

    ap_v_d    = ap_v_q;
    ap_addr_d = ap_addr_q;
    ap_byte_d = ap_byte_q;
    if (pop) begin
      ap_v_d    = 1'b1;
      ap_addr_d = head[39:8];
      ap_byte_d = head[7:0];
    end else if (ap_done) begin
      ap_v_d    = 1'b0;
    end

    ap_hold_d = ap_hold_q;
    if (HRESP && !HREADY) begin
      ap_hold_d = 1'b1;
    end else if (HREADY) begin
      ap_hold_d = 1'b0;
    end

    // Data phase register: loaded as the address phase completes, otherwise
    // retired by HREADY. HWDATA is kept after retirement to stay stable.
    dp_v_d   = dp_v_q;
    hwdata_d = hwdata_q;
    if (ap_done) begin
      dp_v_d   = 1'b1;
      hwdata_d = {24'b0, ap_byte_q} << {lane, 3'b000};
    end else if (HREADY) begin
      dp_v_d   = 1'b0;
    end

    htrans = ap_nonseq ? TR_NONSEQ : TR_IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= {in_address, in_byte};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ap_v_q    <= 1'b0;
      ap_addr_q <= '0;
      ap_byte_q <= '0;
      ap_hold_q <= 1'b0;
      dp_v_q    <= 1'b0;
      hwdata_q  <= '0;
      ovf_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ap_v_q    <= ap_v_d;
      ap_addr_q <= ap_addr_d;
      ap_byte_q <= ap_byte_d;
      ap_hold_q <= ap_hold_d;
      dp_v_q    <= dp_v_d;
      hwdata_q  <= hwdata_d;
      ovf_q     <= ovf_d;
      berr_q    <= berr_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign busy      = !fifo_empty || ap_v_q || dp_v_q;
  assign overflow  = ovf_q;
  assign bus_error = berr_q;
  assign HADDR     = ap_addr_q & ADDR_MASK;
  assign HTRANS    = htrans;
  assign HWRITE    = ap_nonseq;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0000;
  assign HSIZE     = 3'b000;

endmodule

// File: tb/tb_mfp_srec_ahb_byte_writer.sv
module tb_mfp_srec_ahb_byte_writer;

  localparam int DEPTH = 8;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        in_valid;
  logic [31:0] in_address;
  logic [7:0]  in_byte;
  logic        in_ready, busy, overflow, bus_error;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY, HRESP;

  mfp_srec_ahb_byte_writer #(
    .FIFO_DEPTH    (DEPTH),
    .ADDR_KEEP_BITS(29)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .in_valid  (in_valid),
    .in_address(in_address),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .busy      (busy),
    .overflow  (overflow),
    .bus_error (bus_error),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HPROT     (HPROT),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] haddr;
    logic [31:0] hwdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Hand-written lane table for the expected write data.
  function automatic logic [31:0] lane(input logic [31:0] a, input logic [7:0] b);
`ifdef MFP_SREC_WRITER_BIG_ENDIAN_EN
    case (a[1:0])
      2'd0:    return {b, 24'h0};
      2'd1:    return {8'h0, b, 16'h0};
      2'd2:    return {16'h0, b, 8'h0};
      default: return {24'h0, b};
    endcase
`else
    case (a[1:0])
      2'd0:    return {24'h0, b};
      2'd1:    return {16'h0, b, 8'h0};
      2'd2:    return {8'h0, b, 16'h0};
      default: return {b, 24'h0};
    endcase
`endif
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] b, input bit expect_it);
    in_valid   = 1'b1;
    in_address = a;
    in_byte    = b;
    if (expect_it) exp_q.push_back('{a & 32'h1FFF_FFFF, lane(a, b)});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'b0, busy}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_htrans"},    {30'b0, HTRANS},    32'h0);
    chk({tag, "_haddr"},     HADDR,              32'h0);
    chk({tag, "_hwrite"},    {31'b0, HWRITE},    32'h0);
    chk({tag, "_hwdata"},    HWDATA,             32'h0);
    chk({tag, "_overflow"},  {31'b0, overflow},  32'h0);
    chk({tag, "_bus_error"}, {31'b0, bus_error}, 32'h0);
    chk({tag, "_busy"},      {31'b0, busy},      32'h0);
    chk({tag, "_in_ready"},  {31'b0, in_ready},  32'h1);
  endtask

  // Monitor: pops the scoreboard on every completed address phase, checks
  // HWDATA across the following data phase and bus stability in wait states.
  initial begin : monitor
    logic        dp_pend;
    logic [31:0] dp_exp;
    logic        st_v;
    logic [31:0] st_addr;
    logic [1:0]  st_trans;
    int          run;
    exp_t        e;
    dp_pend = 1'b0; dp_exp = '0; st_v = 1'b0; st_addr = '0; st_trans = '0; run = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp_pend = 1'b0;
        st_v    = 1'b0;
        run     = 0;
      end else begin
        if (st_v) begin
          chk("stall_haddr",  HADDR,            st_addr);
          chk("stall_htrans", {30'b0, HTRANS},  {30'b0, st_trans});
        end
        if (dp_pend) begin
          chk("dp_hwdata", HWDATA, dp_exp);
          if (HREADY) dp_pend = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          run++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got transfer at 0x%08h, want none", HADDR);
          end else begin
            e = exp_q.pop_front();
            chk("haddr", HADDR, e.haddr);
            chk("ctrl", {20'h0, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}, 32'h0000_0800);
            dp_pend = 1'b1;
            dp_exp  = e.hwdata;
          end
        end else begin
          if (run != 0) last_run = run;
          run = 0;
        end
        st_v     = (HTRANS == 2'b10) && !HREADY && !HRESP;
        st_addr  = HADDR;
        st_trans = HTRANS;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    HRESET = 1'b1; in_valid = 1'b0; in_address = '0; in_byte = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check_reset_state("por");

    // Single byte: 2-cycle latency, data one cycle later, busy then drops.
    push(32'h1FC0_0002, 8'hA5, 1'b1);
    chk("t1_lat_idle",   {30'b0, HTRANS}, 32'h0);
    tick();
    chk("t1_lat_nonseq", {30'b0, HTRANS}, 32'h2);
    tick();
    chk("t1_busy_dp",    {31'b0, busy},   32'h1);
    tick();
    chk("t1_busy_drop",  {31'b0, busy},   32'h0);

    // Upper address bits cleared.
    push(32'hBFC0_0000, 8'h5A, 1'b1);
    wait_idle("t2_drain", 20);

    // Four back-to-back bytes across all lanes.
    for (int i = 0; i < 4; i++) push(32'(i), 8'(8'h11 * (i + 1)), 1'b1);
    wait_idle("t3_drain", 20);
    chk("t3_b2b_run", 32'(last_run), 32'd4);

    // Wait states: A in data phase, B in address phase, held for 3 cycles.
    push(32'h100, 8'h01, 1'b1);
    push(32'h101, 8'h02, 1'b1);
    tick();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_trans", {30'b0, HTRANS}, 32'h2);
      chk("t4_stall_addr",  HADDR,  32'h101);
      chk("t4_stall_data",  HWDATA, lane(32'h100, 8'h01));
      if (i < 2) tick();
    end
    for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(i), 8'(8'h80 + i), 1'b1);
    chk("t4_in_ready_full", {31'b0, in_ready}, 32'h0);
    chk("t4_ovf_before",    {31'b0, overflow}, 32'h0);
    push(32'h2FF, 8'hFF, 1'b0);
    chk("t4_overflow",      {31'b0, overflow}, 32'h1);
    HREADY = 1'b1;
    wait_idle("t4_drain", 100);
    chk("t4_ovf_sticky",    {31'b0, overflow}, 32'h1);
    chk("t4_in_ready",      {31'b0, in_ready}, 32'h1);

    // Two-cycle ERROR on byte N; N+1 is cancelled then reissued.
    push(32'h300, 8'hE1, 1'b1);
    push(32'h301, 8'hE2, 1'b1);
    tick();
    chk("t5_berr_clear", {31'b0, bus_error}, 32'h0);
    HRESP = 1'b1; HREADY = 1'b0;
    tick();
    chk("t5_bus_error",  {31'b0, bus_error}, 32'h1);
    chk("t5_err2_idle",  {30'b0, HTRANS},    32'h0);
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    chk("t5_reissue_trans", {30'b0, HTRANS}, 32'h2);
    chk("t5_reissue_addr",  HADDR,           32'h301);
    wait_idle("t5_drain", 20);
    chk("t5_berr_sticky", {31'b0, bus_error}, 32'h1);

    // Reset mid-burst: one byte stuck in address phase, three buffered.
    HREADY = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i), 8'(8'hC0 + i), 1'b0);
    chk("t6_busy_pre",  {31'b0, busy},   32'h1);
    chk("t6_trans_pre", {30'b0, HTRANS}, 32'h2);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    HREADY = 1'b1;
    check_reset_state("t6");
    repeat (3) tick();
    chk("t6_quiet_trans", {30'b0, HTRANS}, 32'h0);
    chk("t6_quiet_busy",  {31'b0, busy},   32'h0);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
